seed_round_ctrl: RTL

- Byte-serial Feistel round datapath and sequencer for the 8-bit SEED core.
- Accepts a 128-bit block as 16 bytes and holds the L/R halves.
- Drives the F-function byte stream and the shared main_counter, and XORs the F result back into L.
- Runs 16 rounds, then streams the 16 result bytes out. Sits directly upstream and downstream of the F-function stage and alongside the key schedule, which reads main_counter/round_idx.

---
 rtl/seed_round_ctrl_pkg.sv | 45 ++++
 rtl/seed_block_shreg.sv | 52 +++++
 rtl/seed_round_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seed_round_ctrl_pkg.sv
// seed_pkg: shared constants, FSM state type, block type and byte helpers
// for the byte-serial SEED Feistel round controller.
package seed_pkg;

  localparam int SEED_ROUNDS       = 16;
  localparam int SEED_BLOCK_BYTES  = 16;
  localparam int SEED_ROUND_CYCLES = 32;
  localparam int SEED_F_OUT_START  = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROUND  = 2'd2,
    UNLOAD = 2'd3
  } seed_state_e;

  // Byte 0 is bits 127:120 (L MSB), byte 15 is bits 7:0 (R LSB).
  typedef logic [127:0] seed_block_t;

  // Return byte idx of the block, byte 0 being the most significant.
  function automatic logic [7:0] seed_pick_byte(input seed_block_t blk, input logic [3:0] idx);
    logic [7:0] val;
    val = 8'h00;
    for (int b = 0; b < SEED_BLOCK_BYTES; b++) begin
      if (idx == 4'(b)) begin
        val = blk[127-8*b -: 8];
      end
    end
    return val;
  endfunction

  // Return the block with byte idx XORed by val.
  function automatic seed_block_t seed_xor_byte(input seed_block_t blk, input logic [3:0] idx,
                                                input logic [7:0] val);
    seed_block_t res;
    res = blk;
    for (int b = 0; b < SEED_BLOCK_BYTES; b++) begin
      if (idx == 4'(b)) begin
        res[127-8*b -: 8] = blk[127-8*b -: 8] ^ val;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seed_block_shreg.sv
// seed_block_shreg: 128-bit L/R block register. Supports a byte shift toward
// the MSB end (load and unload), a per-cycle XOR of one F result byte pair into
// L, and an L/R half swap that sees the XOR result of the same cycle.
module seed_block_shreg
  import seed_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        shift_en,
  input  logic [7:0]  shift_byte,
  input  logic        xor_en,
  input  logic [1:0]  xor_sel,
  input  logic [7:0]  xor_c,
  input  logic [7:0]  xor_d,
  input  logic        swap_en,
  output seed_block_t blk
);

  seed_block_t blk_q;
  seed_block_t blk_x;
  seed_block_t blk_d;

  // XOR F result bytes into L (upper word byte j and lower word byte j), then optionally swap halves.
  always_comb begin
    blk_x = blk_q;
    blk_d = blk_q;
    if (xor_en) begin
      blk_x = seed_xor_byte(seed_xor_byte(blk_q, {2'b00, xor_sel}, xor_c), {2'b01, xor_sel}, xor_d);
    end else begin
      blk_x = blk_q;
    end
    if (shift_en) begin
      blk_d = {blk_q[119:0], shift_byte};
    end else if (swap_en) begin
      blk_d = {blk_x[63:0], blk_x[127:64]};
    end else begin
      blk_d = blk_x;
    end
  end

  // Block storage register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_q <= 128'd0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign blk = blk_q;

endmodule

// File: rtl/seed_round_ctrl.sv
// seed_round_ctrl: byte-serial Feistel round sequencer for the 8-bit SEED core.
// Loads 16 bytes, runs ROUNDS rounds of ROUND_CYCLES cycles each against the
// external F stage, then streams 16 result bytes out.
// Optional build macro SEED_DECRYPT_EN adds a decrypt input that makes
// round_idx count down so the key schedule supplies reversed subkeys.
module seed_round_ctrl
  import seed_pkg::*;
#(
  parameter int ROUNDS       = SEED_ROUNDS,
  parameter int ROUND_CYCLES = SEED_ROUND_CYCLES,
  parameter int F_OUT_START  = SEED_F_OUT_START
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef SEED_DECRYPT_EN
  input  logic       decrypt,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic [7:0] f_c,
  output logic [7:0] f_d,
  input  logic [7:0] f_cn,
  input  logic [7:0] f_dn,
  output logic [4:0] main_counter,
  output logic [3:0] round_idx,
  output logic       busy
);

  localparam logic [4:0] MC_LAST  = 5'(ROUND_CYCLES - 1);
  localparam logic [4:0] MC_F0    = 5'(F_OUT_START);
  localparam logic [3:0] RND_LAST = 4'(ROUNDS - 1);

  seed_state_e state_q, state_d;
  logic [4:0]  mc_q, mc_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;

  logic        in_fire_s;
  logic        out_fire_s;
  logic        round_end_s;
  logic        last_round_s;
  logic        f_win_s;
  logic [4:0]  f_off_s;
  logic        swap_s;
  seed_block_t blk_s;

  assign in_fire_s    = in_valid && (state_q == LOAD);
  assign out_fire_s   = out_ready && (state_q == UNLOAD);
  assign round_end_s  = (state_q == ROUND) && (mc_q == MC_LAST);
  assign last_round_s = (rnd_q == RND_LAST);
  assign f_off_s      = mc_q - MC_F0;
  assign f_win_s      = (state_q == ROUND) && (mc_q >= MC_F0) && (f_off_s < 5'd4);
  assign swap_s       = round_end_s && !last_round_s;

  seed_block_shreg u_shreg (
    .clk        (clk),
    .reset_n    (reset_n),
    .shift_en   (in_fire_s || out_fire_s),
    .shift_byte (in_fire_s ? in_byte : 8'h00),
    .xor_en     (f_win_s),
    .xor_sel    (f_off_s[1:0]),
    .xor_c      (f_cn),
    .xor_d      (f_dn),
    .swap_en    (swap_s),
    .blk        (blk_s)
  );

`ifdef SEED_DECRYPT_EN
  logic dec_q;

  // Capture the direction with the first byte of each block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_q <= 1'b0;
    end else if (in_fire_s && (byte_cnt_q == 4'd0)) begin
      dec_q <= decrypt;
    end else begin
      dec_q <= dec_q;
    end
  end
`endif

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mc_q       <= 5'd0;
      rnd_q      <= 4'd0;
      byte_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      mc_q       <= mc_d;
      rnd_q      <= rnd_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (in_fire_s && (byte_cnt_q == 4'd15)) begin
          state_d = ROUND;
        end else begin
          state_d = LOAD;
        end
      end
      ROUND: begin
        if (round_end_s && last_round_s) begin
          state_d = UNLOAD;
        end else begin
          state_d = ROUND;
        end
      end
      UNLOAD: begin
        if (out_fire_s && (byte_cnt_q == 4'd15)) begin
          state_d = IDLE;
        end else begin
          state_d = UNLOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter next values: byte count in LOAD/UNLOAD, cycle and round count in ROUND.
  always_comb begin
    mc_d       = 5'd0;
    rnd_d      = 4'd0;
    byte_cnt_d = 4'd0;
    case (state_q)
      LOAD: begin
        if (in_fire_s) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      ROUND: begin
        if (round_end_s) begin
          mc_d  = 5'd0;
          rnd_d = last_round_s ? 4'd0 : (rnd_q + 4'd1);
        end else begin
          mc_d  = mc_q + 5'd1;
          rnd_d = rnd_q;
        end
      end
      UNLOAD: begin
        if (out_fire_s) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      default: begin
        byte_cnt_d = 4'd0;
      end
    endcase
  end

  // Outputs decoded from state, counters and block register.
  always_comb begin
    in_ready     = (state_q == LOAD);
    out_valid    = (state_q == UNLOAD);
    busy         = (state_q == ROUND);
    main_counter = mc_q;
    out_byte     = 8'h00;
    f_c          = 8'h00;
    f_d          = 8'h00;
`ifdef SEED_DECRYPT_EN
    if ((state_q == ROUND) && dec_q) begin
      round_idx = RND_LAST - rnd_q;
    end else begin
      round_idx = rnd_q;
    end
`else
    round_idx = rnd_q;
`endif
    if (state_q == UNLOAD) begin
      out_byte = seed_pick_byte(blk_s, 4'd0);
    end else begin
      out_byte = 8'h00;
    end
    // F inputs: byte k of each R word during the first four cycles of a round.
    if ((state_q == ROUND) && (mc_q < 5'd4)) begin
      f_c = seed_pick_byte(blk_s, {2'b10, mc_q[1:0]});
      f_d = seed_pick_byte(blk_s, {2'b11, mc_q[1:0]});
    end else begin
      f_c = 8'h00;
      f_d = 8'h00;
    end
  end

endmodule
